// File: rtl/mc_pkg.sv
// Shared constants for the multicycle main control unit: opcodes, state
// encoding, ALU operation codes and datapath select encodings.
package mc_pkg;

    // Opcode field values (instruction bits [31:26]) of the supported subset.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control FSM states; codes 12-15 are unused and recover to fetch.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // Operation requests to the downstream ALU control decoder.
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU operand B select encodings.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select encodings.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Bundle between the main control unit and the multicycle datapath.
// The master side is the control unit; the slave side is the datapath.
interface mc_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  Opcode, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state_dbg
    );

    modport slave (
        output Opcode, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle main control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with memory-ready stalls and a sticky illegal-opcode
// flag. Outputs depend on the registered state, gated only by mem_ready,
// Zero (for the branch PC enable) and the reset input.
module mc_control
    import mc_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
);

    state_e state_r;
    state_e state_nx_s;
    logic   illegal_op_r;
    logic   illegal_hit_s;
    logic   mem_rdy_s;
    logic   pc_write_s;
    logic   branch_s;

    // With the handshake disabled every memory access completes at once.
    assign mem_rdy_s = USE_MEM_READY ? bus.mem_ready : 1'b1;

    // State register and sticky illegal-opcode flag, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_FETCH;
            illegal_op_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (illegal_hit_s) begin
                illegal_op_r <= 1'b1;
            end else begin
                illegal_op_r <= illegal_op_r;
            end
        end
    end

    // Next-state and output decode; reset forces fetch selects with all writes off.
    always_comb begin
        state_nx_s    = S_FETCH;
        illegal_hit_s = 1'b0;
        pc_write_s    = 1'b0;
        branch_s      = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_REG;
        bus.ALUOp     = ALUOP_ADD;
        bus.PCSrc     = PCSRC_ALU;
        if (!rst_n) begin
            bus.ALUSrcB = SRCB_FOUR;
        end else begin
            case (state_r)
                S_FETCH: begin
                    bus.ALUSrcB = SRCB_FOUR;
                    if (mem_rdy_s) begin
                        bus.IRWrite = 1'b1;
                        pc_write_s  = 1'b1;
                        state_nx_s  = S_DECODE;
                    end else begin
                        state_nx_s  = S_FETCH;
                    end
                end
                S_DECODE: begin
                    bus.ALUSrcB = SRCB_IMM_SH2;
                    case (bus.Opcode)
                        OP_LW, OP_SW: state_nx_s = S_MEMADR;
                        OP_RTYPE:     state_nx_s = S_EXEC;
                        OP_BEQ:       state_nx_s = S_BEQ;
                        OP_ADDI:      state_nx_s = S_ADDIEX;
                        OP_J:         state_nx_s = S_JUMP;
                        default: begin
                            state_nx_s    = S_FETCH;
                            illegal_hit_s = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    if (bus.Opcode == OP_SW) begin
                        state_nx_s = S_MEMWR;
                    end else begin
                        state_nx_s = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    bus.IorD = 1'b1;
                    if (mem_rdy_s) begin
                        state_nx_s = S_MEMWB;
                    end else begin
                        state_nx_s = S_MEMRD;
                    end
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    // Write strobe stays up until memory accepts it.
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                    if (mem_rdy_s) begin
                        state_nx_s = S_FETCH;
                    end else begin
                        state_nx_s = S_MEMWR;
                    end
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = ALUOP_FUNC;
                    state_nx_s  = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BEQ: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = ALUOP_SUB;
                    bus.PCSrc   = PCSRC_ALUOUT;
                    branch_s    = 1'b1;
                end
                S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    state_nx_s  = S_ADDIWB;
                end
                S_ADDIWB: begin
                    bus.RegWrite = 1'b1;
                end
                S_JUMP: begin
                    bus.PCSrc  = PCSRC_JUMP;
                    pc_write_s = 1'b1;
                end
                default: begin
                    state_nx_s = S_FETCH;
                end
            endcase
        end
        // Zero acts in the same cycle so a taken branch loads the PC in BEQ.
        bus.PCEn = pc_write_s | (branch_s & bus.Zero);
    end

    assign bus.illegal_op = illegal_op_r;
    assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control. A reference model expands each
// instruction into its expected per-cycle state trace (including injected
// memory wait cycles) and derives the expected control word of every cycle.
module tb_mc_control;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   illegal_exp = 1'b0;

    mc_control_if bus_if();

    mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
    } ctl_t;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    // Expected control word from the per-state output list.
    function automatic ctl_t exp_ctl(input int st, input bit rdy, input bit z, input bit rstn);
        ctl_t c = '0;
        bit pcwrite = 1'b0;
        bit branch  = 1'b0;
        if (!rstn) begin
            c.alusrcb = 2'b01;
            return c;
        end
        case (st)
            0:  begin c.alusrcb = 2'b01; c.irwrite = rdy; pcwrite = rdy; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            3:  c.iord = 1'b1;
            4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; branch = 1'b1; end
            9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            10: c.regwrite = 1'b1;
            11: begin c.pcsrc = 2'b10; pcwrite = 1'b1; end
            default: ;
        endcase
        c.pcen = pcwrite | (branch & z);
        return c;
    endfunction

    function automatic ctl_t obs_ctl();
        ctl_t c;
        c.iord     = bus_if.IorD;
        c.memwrite = bus_if.MemWrite;
        c.irwrite  = bus_if.IRWrite;
        c.regdst   = bus_if.RegDst;
        c.memtoreg = bus_if.MemtoReg;
        c.regwrite = bus_if.RegWrite;
        c.alusrca  = bus_if.ALUSrcA;
        c.alusrcb  = bus_if.ALUSrcB;
        c.aluop    = bus_if.ALUOp;
        c.pcsrc    = bus_if.PCSrc;
        c.pcen     = bus_if.PCEn;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, compare state, controls and flag, then advance.
    task automatic drive_check(input int st, input bit rdy, input bit z, input string tag);
        bus_if.mem_ready = rdy;
        bus_if.Zero      = z;
        #1;
        check({tag, " state"},   32'(bus_if.state_dbg), 32'(st));
        check({tag, " ctl"},     32'(obs_ctl()), 32'(exp_ctl(st, rdy, z, rst_n)));
        check({tag, " illegal"}, 32'(bus_if.illegal_op), 32'(illegal_exp));
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its expected trace and check it cycle by cycle.
    // zmode: 0 = Zero low, 1 = Zero high, 2 = random each cycle.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input int zmode, input string tag);
        step_t q[$];
        bit legal = 1'b1;
        bit z;
        for (int i = 0; i < wf; i++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'($urandom)});
        case (op)
            6'b100011: begin
                q.push_back('{2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{3, 1'b0});
                q.push_back('{3, 1'b1});
                q.push_back('{4, 1'($urandom)});
            end
            6'b101011: begin
                q.push_back('{2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{5, 1'b0});
                q.push_back('{5, 1'b1});
            end
            6'b000000: begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
            6'b001000: begin q.push_back('{9, 1'($urandom)}); q.push_back('{10, 1'($urandom)}); end
            6'b000100: q.push_back('{8, 1'($urandom)});
            6'b000010: q.push_back('{11, 1'($urandom)});
            default:   legal = 1'b0;
        endcase
        bus_if.Opcode = op;
        foreach (q[i]) begin
            z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            drive_check(q[i].st, q[i].rdy, z, tag);
            if (q[i].st == 1 && !legal) illegal_exp = 1'b1;
        end
        check({tag, " end"}, 32'(bus_if.state_dbg), 32'd0);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        // Reset: enables forced low, fetch selects shown even before the first edge.
        rst_n            = 1'b0;
        bus_if.Opcode    = 6'b000000;
        bus_if.mem_ready = 1'b1;
        bus_if.Zero      = 1'b1;
        #1;
        check("reset ctl pre-edge", 32'(obs_ctl()), 32'(exp_ctl(0, 1'b1, 1'b1, 1'b0)));
        @(posedge clk);
        #1;
        drive_check(0, 1'b1, 1'b1, "reset hold");
        rst_n = 1'b1;

        // Directed instructions.
        run_instr(6'b100011, 0, 0, 2, "lw");
        run_instr(6'b000000, 0, 0, 2, "rtype");
        run_instr(6'b000100, 0, 0, 1, "beq taken");
        run_instr(6'b000100, 0, 0, 0, "beq not taken");
        run_instr(6'b101011, 2, 3, 2, "sw stall");
        run_instr(6'b000010, 0, 0, 2, "j");
        run_instr(6'b111111, 0, 0, 2, "illegal");
        run_instr(6'b001000, 0, 0, 2, "addi after illegal");
        run_instr(6'b100011, 1, 2, 2, "lw stall");

        // Reset pulled mid-instruction while in MEMRD.
        bus_if.Opcode = 6'b100011;
        drive_check(0, 1'b1, 1'b0, "rst pre fetch");
        drive_check(1, 1'b1, 1'b0, "rst pre decode");
        drive_check(2, 1'b1, 1'b0, "rst pre memadr");
        rst_n = 1'b0;
        drive_check(3, 1'b1, 1'b1, "rst in memrd");
        illegal_exp = 1'b0;
        drive_check(0, 1'b1, 1'b1, "rst after edge");
        rst_n = 1'b1;

        // Randomized instruction stream with random stalls and Zero.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 2, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback for the MIPS subset. It sits directly upstream of the ALU control decoder and drives its 2-bit `ALUOp` (00 add, 01 sub, 10 use Func), plus every datapath mux select and write enable. Memory accesses use a ready handshake, so the unit stalls on slow memory.

## Interface
- `USE_MEM_READY`, default 1: when 0, `mem_ready` is ignored and treated as constant 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `Opcode`  in  6  instruction bits [31:26], taken from the instruction register.
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  register write address select: 1 = rd, 0 = rt.
- `MemtoReg`  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  ALU operand A select: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU operand B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp`  out  2  to the ALU control decoder.
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load enable.
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded.
- `state_dbg`  out  4  current state, for debug.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- State encoding and asserted outputs. Any output not listed is 0. `IorD`, `RegDst`, `MemtoReg`, `ALUSrcA`, `PCSrc` and `ALUSrcB` default to 0; `ALUOp` defaults to 00.
  - FETCH=0: ALUSrcB=01, `IRWrite`, PCWrite.
  - DECODE=1: ALUSrcB=11.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10.
  - MEMRD=3: IorD=1.
  - MEMWB=4: MemtoReg=1, `RegWrite`.
  - MEMWR=5: IorD=1, `MemWrite`.
  - EXEC=6: ALUSrcA=1, ALUOp=10.
  - ALUWB=7: RegDst=1, `RegWrite`.
  - BEQ=8: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB=10: `RegWrite`.
  - JUMP=11: PCSrc=10, PCWrite.
  - Codes 12-15: unused.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise FETCH holds.
  - DECODE→MEMADR for lw or sw, EXEC for R-type, BEQ for beq, ADDIEX for addi, JUMP for j.
  - DECODE→FETCH for any other opcode, and `illegal_op` is set.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB when `mem_ready`; otherwise MEMRD holds.
  - MEMWR→FETCH when `mem_ready`; otherwise MEMWR holds.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BEQ and JUMP all go to FETCH.
  - Unused codes go to FETCH.
- Handshake gating:
  - `IRWrite` and PCWrite in FETCH are asserted only in the cycle `mem_ready`=1.
  - `MemWrite` is held high throughout MEMWR until and including the `mem_ready` cycle.
- `PCEn` = PCWrite | (Branch & `Zero`), combinational, so `Zero` affects `PCEn` in the same cycle.
- Reset:
  - While `rst_n`=0, every write enable (`MemWrite`, `IRWrite`, `RegWrite`, `PCEn`) is forced to 0.
  - Selects show FETCH values: ALUSrcB=01, all others 0.
  - On the first rising edge with `rst_n`=0: state becomes FETCH and `illegal_op` becomes 0.
  - A reset asserted mid-instruction abandons that instruction; no write is issued after that edge.

## Timing
- Outputs are a function of the registered state only, except for the `mem_ready`, `Zero` and `rst_n` gating above.
- Minimum cycles per instruction, with `mem_ready` always 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `illegal_op` rises on the edge that leaves DECODE.
- `illegal_op` stays high until reset, including across later legal instructions.

## Structure
- Shared package `mc_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - state encoding constants S_FETCH…S_JUMP;
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10).
- Single module, no sub-modules.
- Two processes: a state register process, and a combined next-state / output decode process.

## Test plan
- Reset, then `Opcode`=100011 with `mem_ready`=1. Required state trace: 0,1,2,3,4,0. In state 4, `RegWrite`=1 and `MemtoReg`=1.
- R-type (`Opcode`=000000). EXEC shows ALUOp=10, ALUSrcA=1, ALUSrcB=00. ALUWB shows `RegWrite`=1 and RegDst=1. The instruction takes 4 cycles.
- beq with `Zero`=1: `PCEn`=1 and PCSrc=01 in BEQ. Same with `Zero`=0: `PCEn`=0. Both take 3 cycles.
- sw with `mem_ready` low for 3 cycles in MEMWR. `MemWrite` must stay 1 for 4 cycles, then the state returns to FETCH. `IRWrite` must stay 0 while `mem_ready` is low in FETCH.
- `Opcode`=111111: state returns to FETCH after DECODE and `illegal_op`=1. A following addi still completes in 4 cycles, and `illegal_op` stays 1.
- Pull `rst_n` low during MEMRD. On that edge the state becomes 0, all write enables read 0, and `illegal_op` is cleared.
